// File: rtl/camera_capture_multi.sv
// rtl/camera_capture_multi.sv - DVP camera capture with multi-byte pixel assembly,
// power-of-two decimation, (x, y) tagging and line/frame geometry checking.
module camera_capture_multi #(
  parameter int BYTES_PER_PIXEL = 2,
  parameter int H_PIXELS        = 320,
  parameter int V_LINES         = 240,
  parameter int X_WIDTH         = 10,
  parameter int Y_WIDTH         = 9,
  parameter int DEC_LOG2        = 0
) (
  input  logic                         cam_clk_in,
  input  logic                         rst_in,
  input  logic                         vsync_in,
  input  logic                         href_in,
  input  logic [7:0]                   pixel_in,
  input  logic                         enable_in,
  output logic [8*BYTES_PER_PIXEL-1:0] pixel_out,
  output logic                         pixel_valid_out,
  output logic [X_WIDTH-1:0]           hcount_out,
  output logic [Y_WIDTH-1:0]           vcount_out,
  output logic                         frame_done_out,
  output logic                         line_error_out,
  output logic                         frame_error_out,
  output logic [15:0]                  frame_count_out
);

  localparam int                 PW       = 8 * BYTES_PER_PIXEL;
  localparam logic [1:0]         LAST_IDX = 2'(BYTES_PER_PIXEL - 1);
  localparam logic [X_WIDTH-1:0] H_MAX    = X_WIDTH'(H_PIXELS);
  localparam logic [Y_WIDTH-1:0] V_MAX    = Y_WIDTH'(V_LINES);
  localparam logic [X_WIDTH-1:0] X_MASK   = X_WIDTH'((1 << DEC_LOG2) - 1);
  localparam logic [Y_WIDTH-1:0] Y_MASK   = Y_WIDTH'((1 << DEC_LOG2) - 1);

  typedef enum logic [1:0] {SYNC, BLANK, ACTIVE, SKIP} state_t;

  state_t             state, state_next;
  logic [1:0]         byte_idx;
  logic [X_WIDTH-1:0] raw_x;
  logic [Y_WIDTH-1:0] raw_y;
  logic               href_q;
  logic [PW-1:0]      pixel_buf;

  logic               clear_cnt, line_end, frame_end, byte_en;
  logic               final_byte, keep, line_bad;
  logic [X_WIDTH-1:0] raw_x_inc;
  logic [Y_WIDTH-1:0] raw_y_inc, lines_seen;
  logic [PW-1:0]      pixel_next;

  always_ff @(posedge cam_clk_in or posedge rst_in) begin
    if (rst_in) state <= SYNC;
    else        state <= state_next;
  end

  // vsync rising during href closes the partial line in the same cycle as the frame.
  always_comb begin
    state_next = state;
    clear_cnt  = 1'b0;
    line_end   = 1'b0;
    frame_end  = 1'b0;
    byte_en    = 1'b0;
    case (state)
      SYNC: if (vsync_in) state_next = BLANK;
      BLANK: begin
        clear_cnt = 1'b1;
        if (!vsync_in) state_next = enable_in ? ACTIVE : SKIP;
      end
      SKIP: if (vsync_in) state_next = BLANK;
      ACTIVE: begin
        line_end  = href_q && (!href_in || vsync_in);
        frame_end = vsync_in;
        byte_en   = href_in && !vsync_in;
        if (vsync_in) state_next = BLANK;
      end
      default: state_next = SYNC;
    endcase
  end

  always_comb begin
    pixel_next = pixel_buf;
    for (int i = 0; i < BYTES_PER_PIXEL; i++) begin
      if (byte_idx == 2'(BYTES_PER_PIXEL - 1 - i)) pixel_next[i*8 +: 8] = pixel_in;
    end
    final_byte = byte_en && (byte_idx == LAST_IDX);
    keep       = final_byte && (raw_x < H_MAX) && (raw_y < V_MAX) &&
                 ((raw_x & X_MASK) == '0) && ((raw_y & Y_MASK) == '0);
    line_bad   = (byte_idx != 2'd0) || (raw_x != H_MAX);
    raw_x_inc  = (raw_x == H_MAX) ? raw_x : raw_x + X_WIDTH'(1);
    raw_y_inc  = (raw_y == V_MAX) ? raw_y : raw_y + Y_WIDTH'(1);
    lines_seen = line_end ? raw_y_inc : raw_y;
  end

  always_ff @(posedge cam_clk_in or posedge rst_in) begin
    if (rst_in) begin
      byte_idx        <= '0;
      raw_x           <= '0;
      raw_y           <= '0;
      href_q          <= 1'b0;
      pixel_buf       <= '0;
      pixel_out       <= '0;
      pixel_valid_out <= 1'b0;
      hcount_out      <= '0;
      vcount_out      <= '0;
      frame_done_out  <= 1'b0;
      line_error_out  <= 1'b0;
      frame_error_out <= 1'b0;
      frame_count_out <= '0;
    end else begin
      href_q          <= href_in;
      pixel_valid_out <= 1'b0;
      frame_done_out  <= 1'b0;
      line_error_out  <= 1'b0;
      frame_error_out <= 1'b0;
      if (clear_cnt) begin
        byte_idx <= '0;
        raw_x    <= '0;
        raw_y    <= '0;
      end
      if (byte_en) begin
        pixel_buf <= pixel_next;
        byte_idx  <= final_byte ? 2'd0 : byte_idx + 2'd1;
        if (final_byte) raw_x <= raw_x_inc;
      end
      if (keep) begin
        pixel_out       <= pixel_next;
        hcount_out      <= raw_x >> DEC_LOG2;
        vcount_out      <= raw_y >> DEC_LOG2;
        pixel_valid_out <= 1'b1;
      end
      if (line_end) begin
        line_error_out <= line_bad;
        byte_idx       <= '0;
        raw_x          <= '0;
        raw_y          <= raw_y_inc;
      end
      if (frame_end) begin
        frame_done_out  <= 1'b1;
        frame_error_out <= (lines_seen != V_MAX);
        frame_count_out <= frame_count_out + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_camera_capture_multi.sv
// tb/tb_camera_capture_multi.sv - directed bench for camera_capture_multi on a reduced
// 16x12 geometry: BPP=2, BPP=3 and DEC_LOG2=1 instances share one camera bus.
module tb_camera_capture_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, vsync, href, enable;
  logic [7:0] pix;

  logic [15:0] b2_pix;  logic b2_v; logic [9:0] b2_h; logic [8:0] b2_vc;
  logic        b2_fd, b2_le, b2_fe; logic [15:0] b2_fc;
  logic [23:0] b3_pix;  logic b3_v; logic [9:0] b3_h; logic [8:0] b3_vc;
  logic        b3_fd, b3_le, b3_fe; logic [15:0] b3_fc;
  logic [15:0] d_pix;   logic d_v;  logic [9:0] d_h;  logic [8:0] d_vc;
  logic        d_fd, d_le, d_fe;    logic [15:0] d_fc;

  camera_capture_multi #(.BYTES_PER_PIXEL(2), .H_PIXELS(16), .V_LINES(12),
                         .X_WIDTH(10), .Y_WIDTH(9), .DEC_LOG2(0)) u_b2 (
    .cam_clk_in(clk), .rst_in(rst), .vsync_in(vsync), .href_in(href), .pixel_in(pix),
    .enable_in(enable), .pixel_out(b2_pix), .pixel_valid_out(b2_v), .hcount_out(b2_h),
    .vcount_out(b2_vc), .frame_done_out(b2_fd), .line_error_out(b2_le),
    .frame_error_out(b2_fe), .frame_count_out(b2_fc));

  camera_capture_multi #(.BYTES_PER_PIXEL(3), .H_PIXELS(16), .V_LINES(12),
                         .X_WIDTH(10), .Y_WIDTH(9), .DEC_LOG2(0)) u_b3 (
    .cam_clk_in(clk), .rst_in(rst), .vsync_in(vsync), .href_in(href), .pixel_in(pix),
    .enable_in(enable), .pixel_out(b3_pix), .pixel_valid_out(b3_v), .hcount_out(b3_h),
    .vcount_out(b3_vc), .frame_done_out(b3_fd), .line_error_out(b3_le),
    .frame_error_out(b3_fe), .frame_count_out(b3_fc));

  camera_capture_multi #(.BYTES_PER_PIXEL(2), .H_PIXELS(16), .V_LINES(12),
                         .X_WIDTH(10), .Y_WIDTH(9), .DEC_LOG2(1)) u_dec (
    .cam_clk_in(clk), .rst_in(rst), .vsync_in(vsync), .href_in(href), .pixel_in(pix),
    .enable_in(enable), .pixel_out(d_pix), .pixel_valid_out(d_v), .hcount_out(d_h),
    .vcount_out(d_vc), .frame_done_out(d_fd), .line_error_out(d_le),
    .frame_error_out(d_fe), .frame_count_out(d_fc));

  int n_vec = 0;
  int n_fail = 0;

  int b2_nv, b2_bad, b2_nfd, b2_nfe, b2_nle, b3_nv, b3_nle, d_nv, d_maxh;
  int b2_lh, b2_lv, b3_lh, d_lh, d_lv;

  always @(negedge clk) begin
    if (b2_v === 1'b1) begin
      b2_nv++;
      b2_lh = int'(b2_h);
      b2_lv = int'(b2_vc);
      if (b2_pix !== 16'hABCD) b2_bad++;
    end
    if (b2_fd === 1'b1) b2_nfd++;
    if (b2_fe === 1'b1) b2_nfe++;
    if (b2_le === 1'b1) b2_nle++;
    if (b3_v === 1'b1) begin
      b3_nv++;
      b3_lh = int'(b3_h);
    end
    if (b3_le === 1'b1) b3_nle++;
    if (d_v === 1'b1) begin
      d_nv++;
      d_lh = int'(d_h);
      d_lv = int'(d_vc);
      if (int'(d_h) > d_maxh) d_maxh = int'(d_h);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    b2_nv = 0; b2_bad = 0; b2_nfd = 0; b2_nfe = 0; b2_nle = 0;
    b3_nv = 0; b3_nle = 0; d_nv = 0; d_maxh = 0;
    b2_lh = -1; b2_lv = -1; b3_lh = -1; d_lh = -1; d_lv = -1;
  endtask

  task automatic drive(input logic v, input logic h, input logic [7:0] d);
    vsync = v;
    href  = h;
    pix   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int n, input int per, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] c);
    for (int k = 0; k < n; k++) begin
      logic [7:0] d;
      d = (k % per == 0) ? a : ((k % per == 1) ? b : c);
      drive(1'b0, 1'b1, d);
    end
  endtask

  task automatic gap();
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic vsync_open();
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    repeat (2) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic full_frame();
    for (int l = 0; l < 12; l++) begin
      send_line(32, 2, 8'hAB, 8'hCD, 8'h00);
      gap();
    end
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; href = 1'b0; pix = 8'h00; enable = 1'b1;
    clr();
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    chk("reset_valid", 32'(b2_v), 32'd0);
    chk("reset_pixel", 32'(b2_pix), 32'd0);
    chk("reset_fcount", 32'(b2_fc), 32'd0);
    chk("reset_errors", {29'd0, b2_fd, b2_le, b2_fe}, 32'd0);

    // Lines before any vsync are ignored
    rst = 1'b0;
    send_line(32, 2, 8'hAB, 8'hCD, 8'h00);
    gap();
    chk("presync_valids", 32'(b2_nv), 32'd0);

    // Full frame: BPP=2 and decimated instance
    clr();
    vsync_open();
    full_frame();
    drive(1'b1, 1'b0, 8'h00);
    chk("f1_done_pulse", 32'(b2_fd), 32'd1);
    chk("f1_err_pulse", 32'(b2_fe), 32'd0);
    chk("f1_fcount", 32'(b2_fc), 32'd1);
    drive(1'b1, 1'b0, 8'h00);
    chk("f1_done_one_cycle", 32'(b2_fd), 32'd0);
    chk("f1_valids", 32'(b2_nv), 32'd192);
    chk("f1_bad_pixels", 32'(b2_bad), 32'd0);
    chk("f1_last_h", 32'(b2_lh), 32'd15);
    chk("f1_last_v", 32'(b2_lv), 32'd11);
    chk("f1_done_count", 32'(b2_nfd), 32'd1);
    chk("f1_line_errs", 32'(b2_nle + b2_nfe), 32'd0);
    chk("dec_valids", 32'(d_nv), 32'd48);
    chk("dec_max_h", 32'(d_maxh), 32'd7);
    chk("dec_last_h", 32'(d_lh), 32'd7);
    chk("dec_last_v", 32'(d_lv), 32'd5);
    repeat (2) drive(1'b0, 1'b0, 8'h00);

    // BPP=3 line of 0x11,0x22,0x33
    clr();
    drive(1'b0, 1'b1, 8'h11);
    drive(1'b0, 1'b1, 8'h22);
    chk("b3_no_early_valid", 32'(b3_v), 32'd0);
    drive(1'b0, 1'b1, 8'h33);
    chk("b3_valid", 32'(b3_v), 32'd1);
    chk("b3_pixel", 32'(b3_pix), 32'h112233);
    chk("b3_hv", {b3_h, 7'd0, b3_vc, 6'd0}, 32'd0);
    send_line(45, 3, 8'h11, 8'h22, 8'h33);
    gap();
    chk("b3_valids", 32'(b3_nv), 32'd16);
    chk("b3_last_h", 32'(b3_lh), 32'd15);
    chk("b3_line_errs", 32'(b3_nle), 32'd0);

    // Odd-length line at BPP=2, then realignment
    clr();
    send_line(31, 2, 8'hAB, 8'hCD, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    chk("odd_line_err_pulse", 32'(b2_le), 32'd1);
    drive(1'b0, 1'b0, 8'h00);
    chk("odd_line_err_one_cycle", 32'(b2_le), 32'd0);
    chk("odd_valids", 32'(b2_nv), 32'd15);
    drive(1'b0, 1'b1, 8'hAB);
    drive(1'b0, 1'b1, 8'hCD);
    chk("realign_valid", 32'(b2_v), 32'd1);
    chk("realign_h", 32'(b2_h), 32'd0);
    chk("realign_v", 32'(b2_vc), 32'd2);
    chk("realign_pixel", 32'(b2_pix), 32'hABCD);
    send_line(30, 2, 8'hAB, 8'hCD, 8'h00);
    gap();
    chk("odd_err_count", 32'(b2_nle), 32'd1);
    chk("odd_bad_pixels", 32'(b2_bad), 32'd0);

    // Short frame closed by vsync while href is high
    send_line(10, 2, 8'hAB, 8'hCD, 8'h00);
    drive(1'b1, 1'b1, 8'hAB);
    chk("short_done", 32'(b2_fd), 32'd1);
    chk("short_frame_err", 32'(b2_fe), 32'd1);
    chk("short_line_err", 32'(b2_le), 32'd1);
    chk("short_fcount", 32'(b2_fc), 32'd2);
    drive(1'b1, 1'b0, 8'h00);
    chk("blank_no_line_err", 32'(b2_le), 32'd0);
    repeat (2) drive(1'b0, 1'b0, 8'h00);

    // Asynchronous reset mid-line, released mid-frame
    send_line(10, 2, 8'hAB, 8'hCD, 8'h00);
    rst = 1'b1;
    #2;
    chk("async_rst_fcount", 32'(b2_fc), 32'd0);
    chk("async_rst_valid", 32'(b2_v), 32'd0);
    drive(1'b0, 1'b1, 8'hAB);
    drive(1'b0, 1'b1, 8'hCD);
    rst = 1'b0;
    clr();
    send_line(10, 2, 8'hAB, 8'hCD, 8'h00);
    gap();
    send_line(32, 2, 8'hAB, 8'hCD, 8'h00);
    gap();
    chk("post_rst_no_valids", 32'(b2_nv), 32'd0);
    vsync_open();
    full_frame();
    drive(1'b1, 1'b0, 8'h00);
    chk("clean_done", 32'(b2_fd), 32'd1);
    chk("clean_frame_err", 32'(b2_fe), 32'd0);
    chk("clean_fcount", 32'(b2_fc), 32'd1);
    enable = 1'b0;
    drive(1'b1, 1'b0, 8'h00);
    chk("clean_valids", 32'(b2_nv), 32'd192);
    chk("clean_bad_pixels", 32'(b2_bad), 32'd0);
    chk("clean_line_errs", 32'(b2_nle), 32'd0);

    // enable_in low at frame start; raising it mid-frame has no effect
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    clr();
    for (int l = 0; l < 12; l++) begin
      if (l == 2) enable = 1'b1;
      send_line(32, 2, 8'hAB, 8'hCD, 8'h00);
      gap();
    end
    drive(1'b1, 1'b0, 8'h00);
    chk("skip_no_done", 32'(b2_fd), 32'd0);
    chk("skip_fcount", 32'(b2_fc), 32'd1);
    drive(1'b1, 1'b0, 8'h00);
    chk("skip_valids", 32'(b2_nv), 32'd0);
    chk("skip_done_count", 32'(b2_nfd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
